// File: rtl/snapshot_uploader_if.sv
// Upload-path bundle: hps_io upload handshake plus the SDRAM read port.
// The uploader takes the slave view; hps_io and the SDRAM mux take the master view.
interface snapshot_uploader_if;
   logic        ioctl_upload;
   logic        ioctl_rd;
   logic [24:0] ioctl_addr;
   logic [7:0]  ioctl_din;
   logic        ioctl_wait;
   logic        mem_rd;
   logic [22:0] mem_addr;
   logic [1:0]  mem_bank;
   logic [7:0]  mem_dout;

   modport master (
      output ioctl_upload, ioctl_rd, ioctl_addr, mem_dout,
      input  ioctl_din, ioctl_wait, mem_rd, mem_addr, mem_bank
   );

   modport slave (
      input  ioctl_upload, ioctl_rd, ioctl_addr, mem_dout,
      output ioctl_din, ioctl_wait, mem_rd, mem_addr, mem_bank
   );
endinterface

// File: rtl/snapshot_uploader.sv
// Snapshot uploader: serves hps_io upload reads from SDRAM using ce_ref slots,
// holds the machine in reset while an upload session is open, and keeps a
// running byte count and checksum for the session.
module snapshot_uploader #(
   parameter logic [22:0] BASE = 23'h000000,
   parameter int          LEN  = 131072
) (
   input  logic                clk_sys,
   input  logic                reset,
   input  logic                ce_ref,
   input  logic [1:0]          bank,
   snapshot_uploader_if.slave  io,
   output logic                hold,
   output logic [17:0]         byte_cnt,
   output logic [7:0]          checksum
);

   typedef enum logic [1:0] {IDLE, REQ, READ} state_t;

   // Offsets at or beyond this limit are answered with 8'hFF without touching SDRAM.
   localparam logic [25:0] LEN_LIM = 26'(LEN);

   state_t      state_q;
   logic [7:0]  din_q;
   logic        wait_q;
   logic        mem_rd_q;
   logic [22:0] mem_addr_q;
   logic [1:0]  mem_bank_q;
   logic        upload_q;
   logic [17:0] cnt_q;
   logic [7:0]  cks_q;

   logic        upload_rise;
   logic        oor;
   logic [17:0] cnt_d;
   logic [7:0]  cks_d;

   // Byte counter stops at all-ones instead of wrapping.
   function automatic logic [17:0] sat_inc(input logic [17:0] v);
      return (&v) ? v : v + 18'd1;
   endfunction

   // A new session starts the counters from zero; otherwise they carry on.
   always_comb begin
      upload_rise = io.ioctl_upload & ~upload_q;
      oor         = {1'b0, io.ioctl_addr} >= LEN_LIM;
      cnt_d       = upload_rise ? 18'd0 : cnt_q;
      cks_d       = upload_rise ? 8'd0  : cks_q;
   end

   // Request FSM: IDLE accepts a read, REQ waits for a slot, READ holds mem_rd for one slot.
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state_q    <= IDLE;
         din_q      <= 8'd0;
         wait_q     <= 1'b0;
         mem_rd_q   <= 1'b0;
         mem_addr_q <= 23'd0;
         mem_bank_q <= 2'd0;
         upload_q   <= 1'b0;
         cnt_q      <= 18'd0;
         cks_q      <= 8'd0;
      end else begin
         upload_q <= io.ioctl_upload;
         cnt_q    <= cnt_d;
         cks_q    <= cks_d;
         case (state_q)
            IDLE: begin
               if (io.ioctl_rd && io.ioctl_upload) begin
                  if (!oor) begin
                     mem_addr_q <= BASE + io.ioctl_addr[22:0];
                     mem_bank_q <= bank;
                     wait_q     <= 1'b1;
                     state_q    <= REQ;
                  end else begin
                     din_q <= 8'hFF;
                     cnt_q <= sat_inc(cnt_d);
                     cks_q <= cks_d + 8'hFF;
                  end
               end
            end
            REQ: begin
               if (!io.ioctl_upload) begin
                  wait_q   <= 1'b0;
                  mem_rd_q <= 1'b0;
                  state_q  <= IDLE;
               end else if (ce_ref) begin
                  mem_rd_q <= 1'b1;
                  state_q  <= READ;
               end
            end
            READ: begin
               if (!io.ioctl_upload) begin
                  wait_q   <= 1'b0;
                  mem_rd_q <= 1'b0;
                  state_q  <= IDLE;
               end else if (ce_ref) begin
                  din_q    <= io.mem_dout;
                  mem_rd_q <= 1'b0;
                  wait_q   <= 1'b0;
                  cnt_q    <= sat_inc(cnt_d);
                  cks_q    <= cks_d + io.mem_dout;
                  state_q  <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign io.ioctl_din  = din_q;
   assign io.ioctl_wait = wait_q;
   assign io.mem_rd     = mem_rd_q;
   assign io.mem_addr   = mem_addr_q;
   assign io.mem_bank   = mem_bank_q;
   assign hold          = upload_q;
   assign byte_cnt      = cnt_q;
   assign checksum      = cks_q;

endmodule
